// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core load/store unit and the loader.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration instead of core priority + starvation guard.

module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rd,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wd,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              starve_active
);

  typedef enum logic {OWN_CORE = 1'b0, OWN_LD = 1'b1} owner_e;

  logic              w_ld_pri;
  logic              w_sel_ld;
  logic              w_sel_core;
  logic              w_read_gnt;
  logic              r_pend_v;
  owner_e            r_pend_owner;
  logic [DATA_W-1:0] r_core_rd;
  logic [DATA_W-1:0] r_ld_rd;

`ifdef DMEM_ARB_RR_EN
  owner_e r_last_owner;

  // Loader wins a tie only if the core was the last one served.
  assign w_ld_pri      = (r_last_owner == OWN_CORE);
  assign starve_active = 1'b0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_owner <= OWN_CORE;
    end else if (w_sel_ld || w_sel_core) begin
      r_last_owner <= w_sel_ld ? OWN_LD : OWN_CORE;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX - 1);

  logic [7:0] r_starve_cnt;
  logic       r_starve_active;

  assign w_ld_pri      = r_starve_active;
  assign starve_active = rstn & r_starve_active;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_starve_cnt    <= '0;
      r_starve_active <= 1'b0;
    end else begin
      if (w_sel_ld || !ld_req) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != 8'hFF) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
      // A grant clears forced priority even in the cycle the limit is reached.
      if (w_sel_ld) begin
        r_starve_active <= 1'b0;
      end else if (ld_req && (r_starve_cnt == STARVE_LIM)) begin
        r_starve_active <= 1'b1;
      end
    end
  end
`endif

  assign w_sel_ld   = rstn & ld_req & (~core_req | w_ld_pri);
  assign w_sel_core = rstn & core_req & ~w_sel_ld;
  assign core_gnt   = w_sel_core;
  assign ld_gnt     = w_sel_ld;

  // Idle cycles present the core fields with mem_we low; the resulting read is never returned.
  assign mem_a      = w_sel_ld ? ld_addr : core_addr;
  assign mem_wd     = w_sel_ld ? ld_wd   : core_wd;
  assign mem_we     = w_sel_ld ? ld_we   : (w_sel_core & core_we);
  assign w_read_gnt = (w_sel_ld | w_sel_core) & ~mem_we;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend_v     <= 1'b0;
      r_pend_owner <= OWN_CORE;
      r_core_rd    <= '0;
      r_ld_rd      <= '0;
    end else begin
      r_pend_v     <= w_read_gnt;
      r_pend_owner <= w_sel_ld ? OWN_LD : OWN_CORE;
      if (core_rvalid) r_core_rd <= mem_rd;
      if (ld_rvalid)   r_ld_rd   <= mem_rd;
    end
  end

  // NOTE: return outputs are gated by rstn so a read granted just before reset never surfaces.
  assign core_rvalid = rstn & r_pend_v & (r_pend_owner == OWN_CORE);
  assign ld_rvalid   = rstn & r_pend_v & (r_pend_owner == OWN_LD);
  assign core_rd     = !rstn ? '0 : (core_rvalid ? mem_rd : r_core_rd);
  assign ld_rd       = !rstn ? '0 : (ld_rvalid   ? mem_rd : r_ld_rd);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of grants, memory contents and read returns.

module tb_dmem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              core_req, core_we, ld_req, ld_we;
  logic [ADDR_W-1:0] core_addr, ld_addr;
  logic [DATA_W-1:0] core_wd, ld_wd;
  logic              core_gnt, core_rvalid, ld_gnt, ld_rvalid;
  logic [DATA_W-1:0] core_rd, ld_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic              starve_active;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wd(core_wd),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rd(core_rd),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wd(ld_wd),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rd(ld_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .starve_active(starve_active)
  );

  always #5 clk = ~clk;

  // Block-RAM stand-in: registered read, word-indexed by address bits [9:2].
  logic [DATA_W-1:0] fmem [256] = '{default: '0};
  always @(posedge clk) begin
    mem_rd <= fmem[mem_a[9:2]];
    if (mem_we) fmem[mem_a[9:2]] <= mem_wd;
  end

  // Reference model state: what each requester should see.
  logic [DATA_W-1:0] mm [256] = '{default: '0};
  int                streak;
  bit                forced;
  bit                last_was_ld;
  bit                pend_v, pend_ld;
  logic [DATA_W-1:0] pend_data, hold_core, hold_ld;
  bit                g_core, g_ld;

  int vectors    = 0;
  int miscompares = 0;

  logic              s_core_gnt, s_ld_gnt, s_core_rvalid, s_ld_rvalid, s_mem_we, s_starve;
  logic [DATA_W-1:0] s_core_rd, s_ld_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    core_req = req; core_we = we; core_addr = a; core_wd = d;
  endtask

  task automatic set_ld(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    ld_req = req; ld_we = we; ld_addr = a; ld_wd = d;
  endtask

  task automatic model_reset();
    streak = 0; forced = 0; last_was_ld = 0;
    pend_v = 0; pend_ld = 0; pend_data = '0; hold_core = '0; hold_ld = '0;
  endtask

  // One clock cycle with the inputs already driven: predict, sample at negedge, advance the model.
  task automatic cycle();
    bit                e_c, e_l, e_cv, e_lv, e_we, e_st, pref, rst_ok, lreq, wr;
    logic [DATA_W-1:0] e_crd, e_lrd, e_wd, wd;
    logic [ADDR_W-1:0] e_a, a;
    rst_ok = rstn;
    lreq   = ld_req;
`ifdef DMEM_ARB_RR_EN
    pref = !last_was_ld;
    e_st = 1'b0;
`else
    pref = forced;
    e_st = rst_ok && forced;
`endif
    e_l   = rst_ok && ld_req && (!core_req || pref);
    e_c   = rst_ok && core_req && !e_l;
    e_cv  = rst_ok && pend_v && !pend_ld;
    e_lv  = rst_ok && pend_v && pend_ld;
    e_crd = !rst_ok ? '0 : (e_cv ? pend_data : hold_core);
    e_lrd = !rst_ok ? '0 : (e_lv ? pend_data : hold_ld);
    e_a   = e_l ? ld_addr : core_addr;
    e_wd  = e_l ? ld_wd : core_wd;
    e_we  = e_l ? ld_we : (e_c && core_we);
    wr    = e_l ? ld_we : core_we;
    a     = e_a;
    wd    = e_wd;

    @(negedge clk);
    s_core_gnt = core_gnt; s_ld_gnt = ld_gnt; s_core_rvalid = core_rvalid; s_ld_rvalid = ld_rvalid;
    s_core_rd = core_rd; s_ld_rd = ld_rd; s_mem_we = mem_we; s_starve = starve_active;
    check("core_gnt", core_gnt, e_c);
    check("ld_gnt", ld_gnt, e_l);
    check("core_rvalid", core_rvalid, e_cv);
    check("ld_rvalid", ld_rvalid, e_lv);
    check("core_rd", core_rd, e_crd);
    check("ld_rd", ld_rd, e_lrd);
    check("mem_we", mem_we, e_we);
    check("mem_a", mem_a, e_a);
    check("mem_wd", mem_wd, e_wd);
    check("starve_active", starve_active, e_st);

    @(posedge clk);
    if (!rst_ok) begin
      model_reset();
    end else begin
      if (e_cv) hold_core = pend_data;
      if (e_lv) hold_ld = pend_data;
      pend_v = 0;
      if (e_c || e_l) begin
        if (wr) mm[a[9:2]] = wd;
        else begin
          pend_v = 1; pend_ld = e_l; pend_data = mm[a[9:2]];
        end
        last_was_ld = e_l;
      end
      if (e_l || !lreq) streak = 0;
      else streak++;
      if (lreq && !e_l && streak >= STARVE_MAX) forced = 1;
      if (e_l) forced = 0;
    end
    g_core = e_c;
    g_ld   = e_l;
    #1;
  endtask

  initial begin
    logic [7:0] idx;
    model_reset();
    rstn = 1'b0;
    set_core(0, 0, '0, '0);
    set_ld(0, 0, '0, '0);
    #1;
    cycle();
    cycle();
    rstn = 1'b1;

    // Core write then read-back.
    set_core(1, 1, 32'h100, 32'hDEADBEEF);
    cycle();
    check("t1_wr_gnt", s_core_gnt, 1'b1);
    check("t1_wr_mem_we", s_mem_we, 1'b1);
    set_core(1, 0, 32'h100, 32'h0);
    cycle();
    check("t1_rd_gnt", s_core_gnt, 1'b1);
    set_core(0, 0, 32'h0, 32'h0);
    cycle();
    check("t1_core_rvalid", s_core_rvalid, 1'b1);
    check("t1_core_rd", s_core_rd, 32'hDEADBEEF);
    check("t1_ld_rvalid", s_ld_rvalid, 1'b0);

    // Loader alone: write then read-back.
    set_ld(1, 1, 32'h40, 32'h12345678);
    cycle();
    check("t2_wr_gnt", s_ld_gnt, 1'b1);
    set_ld(1, 0, 32'h40, 32'h0);
    cycle();
    check("t2_rd_gnt", s_ld_gnt, 1'b1);
    set_ld(0, 0, 32'h0, 32'h0);
    cycle();
    check("t2_ld_rvalid", s_ld_rvalid, 1'b1);
    check("t2_ld_rd", s_ld_rd, 32'h12345678);
    check("t2_no_starve", s_starve, 1'b0);

    // Alternating-owner reads return in issue order.
    set_core(1, 1, 32'h200, 32'hA1A1A1A1); cycle();
    set_core(1, 1, 32'h204, 32'hB2B2B2B2); cycle();
    set_core(1, 1, 32'h208, 32'hC3C3C3C3); cycle();
    set_core(1, 0, 32'h200, 32'h0); cycle();
    set_core(0, 0, 32'h0, 32'h0);
    set_ld(1, 0, 32'h204, 32'h0); cycle();
    check("t4_core_rv1", s_core_rvalid, 1'b1);
    check("t4_core_rd1", s_core_rd, 32'hA1A1A1A1);
    set_ld(0, 0, 32'h0, 32'h0);
    set_core(1, 0, 32'h208, 32'h0); cycle();
    check("t4_ld_rv", s_ld_rvalid, 1'b1);
    check("t4_ld_rd", s_ld_rd, 32'hB2B2B2B2);
    check("t4_core_quiet", s_core_rvalid, 1'b0);
    set_core(0, 0, 32'h0, 32'h0); cycle();
    check("t4_core_rv2", s_core_rvalid, 1'b1);
    check("t4_core_rd2", s_core_rd, 32'hC3C3C3C3);

    // Reset in the cycle after a granted read.
    set_core(1, 0, 32'h100, 32'h0); cycle();
    check("t5_rd_gnt", s_core_gnt, 1'b1);
    rstn = 1'b0; cycle();
    check("t5_rst_gnt", s_core_gnt, 1'b0);
    check("t5_rst_rvalid", s_core_rvalid, 1'b0);
    check("t5_rst_core_rd", s_core_rd, 32'h0);
    check("t5_rst_ld_rd", s_ld_rd, 32'h0);
    check("t5_rst_mem_we", s_mem_we, 1'b0);
    rstn = 1'b1; cycle();
    check("t5_post_gnt", s_core_gnt, 1'b1);
    check("t5_post_rd_zero", s_core_rd, 32'h0);
    set_core(0, 0, 32'h0, 32'h0); cycle();
    check("t5_post_rvalid", s_core_rvalid, 1'b1);
    check("t5_post_rd", s_core_rd, 32'hDEADBEEF);

    // Both requesting continuously.
    set_core(1, 0, 32'h300, 32'h0);
    set_ld(1, 0, 32'h304, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle();
`ifdef DMEM_ARB_RR_EN
      check("rr_ld_gnt", s_ld_gnt, (i % 2) == 0);
      check("rr_core_gnt", s_core_gnt, (i % 2) == 1);
`else
      if (i < 8) begin
        check("st_core_gnt", s_core_gnt, 1'b1);
        check("st_ld_denied", s_ld_gnt, 1'b0);
        check("st_inactive", s_starve, 1'b0);
      end else if (i == 8) begin
        check("st_forced_active", s_starve, 1'b1);
        check("st_forced_ld_gnt", s_ld_gnt, 1'b1);
        check("st_forced_core", s_core_gnt, 1'b0);
      end else begin
        check("st_cleared", s_starve, 1'b0);
        check("st_core_back", s_core_gnt, 1'b1);
      end
`endif
    end
    set_core(0, 0, 32'h0, 32'h0);
    set_ld(0, 0, 32'h0, 32'h0);
    cycle();

    // Randomized traffic honoring the hold-until-grant handshake.
    for (int n = 0; n < 800; n++) begin
      if (!core_req || g_core) begin
        idx = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0)
          set_core(1, 1'($urandom_range(0, 1)), {22'd0, idx, 2'b00}, $urandom);
        else
          set_core(0, 0, core_addr, core_wd);
      end
      if (!ld_req || g_ld) begin
        idx = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0)
          set_ld(1, 1'($urandom_range(0, 1)), {22'd0, idx, 2'b00}, $urandom);
        else
          set_ld(0, 0, ld_addr, ld_wd);
      end
      rstn = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port block-RAM data memory between two requesters: the core load/store unit and the loader. The loader writes and reads back data through the same port.
- Sits between both requesters and the data memory. Issues at most one memory command per cycle.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Core has fixed priority. A starvation counter guarantees the loader forward progress.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 8, number of consecutive cycles a pending loader request is denied before the loader is forced ahead of the core (1..255).

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset.
- core_req  in  1  core requests an access; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  byte address.
- core_wd  in  DATA_W  write data.
- core_gnt  out  1  command accepted this cycle.
- core_rvalid  out  1  core_rd valid; 1-cycle pulse.
- core_rd  out  DATA_W  read data.
- ld_req, ld_we, ld_addr, ld_wd, ld_gnt, ld_rvalid, ld_rd: same meanings for the loader.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data, registered in memory, valid the cycle after the read command.
- starve_active  out  1  loader currently has forced priority.

Behaviour:
- Handshake:
  - A requester asserts req with we/addr/wd stable until it sees gnt=1 on a clock edge.
  - The transfer occurs in the gnt cycle. req may stay high for back-to-back accesses.
- Grant logic (combinational from req and registered state):
  - sel_ld = ld_req & (~core_req | starve_active). Otherwise core_req wins.
  - Exactly one of core_gnt/ld_gnt is high, or neither.
  - mem_we/mem_a/mem_wd are muxed from the winner.
  - With no grant: mem_we=0 and mem_a/mem_wd hold the core fields. Harmless, because the memory read is ignored.
- Read return:
  - Registered tag rd_pend (valid bit + owner bit) is set on any granted read.
  - Next cycle, owner_rvalid=1 and owner_rd=mem_rd. The other rvalid stays 0.
  - Granted writes produce no rvalid.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
- Starvation counter starve_cnt (8 bit):
  - Increments each cycle ld_req=1 and ld_gnt=0.
  - Cleared on ld_gnt or when ld_req=0.
  - starve_active is a register: set when starve_cnt reaches STARVE_MAX-1 while still denied, cleared on ld_gnt.
  - So the loader is granted on the (STARVE_MAX+1)-th cycle of continuous denial at the latest.
- Rd data outputs: core_rd/ld_rd hold their last returned value between rvalid pulses.
- Reset (rstn=0 sampled at an edge):
  - core_gnt=ld_gnt=0 combinationally while rstn=0, and mem_we=0.
  - core_rvalid=ld_rvalid=0, core_rd=ld_rd=0, starve_cnt=0, starve_active=0, rd_pend cleared.
  - A read granted the cycle before reset asserts returns no rvalid.
- Simultaneous events:
  - Both req in the same cycle with starve_active=0: core wins.
  - ld_gnt in the same cycle the counter would saturate: clear takes precedence.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- When defined:
  - Starvation counter and starve_active are removed; starve_active is tied 0.
  - Arbitration is round-robin on a 1-bit last_owner register (reset 0 = core).
  - When both request, the one not granted last wins. A single requester always wins. last_owner updates on every grant.
- When undefined: fixed core priority with the starvation counter as described above.

Test Plan:
- Core write then read: core_we=1 addr 0x100 wd 0xDEADBEEF; next cycle core read 0x100 -> core_gnt both cycles, mem_we=1 first cycle, core_rvalid=1 one cycle after the read grant with core_rd=0xDEADBEEF, ld_rvalid=0.
- Loader only: ld read 0x40 after ld write 0x12345678 -> ld_gnt both cycles, ld_rvalid pulse with ld_rd=0x12345678, starve_cnt stays 0.
- Starvation, STARVE_MAX=8, core_req and ld_req held high continuously -> core granted cycles 0..7, starve_active=1 from cycle 8, ld_gnt=1 in cycle 8, core_gnt=0 in cycle 8, starve_active=0 in cycle 9.
- Alternating reads core 0x200, loader 0x204, core 0x208 in consecutive grant cycles -> rvalid pulses core, ld, core in consecutive cycles with the matching data.
- Reset mid-read: core read granted, rstn=0 next edge -> no core_rvalid, all outputs 0, gnt=0 while rstn=0; first request after release is granted normally.
- DMEM_ARB_RR_EN defined, both requesting continuously -> grants alternate ld, core, ld, core... starting with ld (last_owner=core after reset).
